// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: controller states and
// default stack-pointer placement used by the post-reset clear sequence.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int SP_IDX_DEFAULT  = 2;
  localparam int SP_INIT_DEFAULT = 1020;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: hardwired zero for register 0, write-to-read
// bypass (port A wins over port B) and zero gating while the clear runs.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] arr_data,
  input  logic            busy,
  input  logic            a_wen,
  input  logic [AW-1:0]   a_addr,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_wen,
  input  logic [AW-1:0]   b_addr,
  input  logic [XLEN-1:0] b_data,
  output logic [XLEN-1:0] data
);

  // a_wen/b_wen already mean "accepted and nonzero target"
  always_comb begin
    data = '0;
    if (!busy && addr != '0) begin
      if (a_wen && a_addr == addr) begin
        data = a_data;
      end else if (b_wen && b_addr == addr) begin
        data = b_data;
      end else begin
        data = arr_data;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a pipeline writeback port, a handshaked
// accelerator write port and a post-reset clear sequence that seeds the SP.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 3,
  parameter int SP_IDX  = SP_IDX_DEFAULT,
  parameter int SP_INIT = SP_INIT_DEFAULT,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      Rst,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  output logic [NRD-1:0][XLEN-1:0]  rd_data,
  input  logic                      a_we,
  input  logic [AW-1:0]             a_addr,
  input  logic [XLEN-1:0]           a_data,
  input  logic                      b_valid,
  input  logic [AW-1:0]             b_addr,
  input  logic [XLEN-1:0]           b_data,
  output logic                      b_ready,
  output logic                      busy
);

  localparam logic [XLEN-1:0] SP_VAL  = XLEN'(SP_INIT);
  localparam logic [AW-1:0]   SP_ADDR = AW'(SP_IDX);
  localparam logic [AW-1:0]   LAST    = AW'(NREGS - 1);

  logic [XLEN-1:0] regdata [NREGS];
  state_t          state;
  logic [AW-1:0]   idx;
  logic            a_acc;
  logic            b_acc;
  logic            b_wr;

  assign busy    = (state == CLEAR);
  assign a_acc   = !busy && a_we && (a_addr != '0);
  assign b_ready = !busy && !(a_we && (a_addr == b_addr) && (a_addr != '0));
  assign b_acc   = b_valid && b_ready;
  assign b_wr    = b_acc && (b_addr != '0);

  // Clear controller: reset restarts the sweep from index 0
  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= CLEAR;
      idx   <= '0;
    end else if (state == CLEAR) begin
      idx <= idx + AW'(1);
      if (idx == LAST) begin
        state <= IDLE;
      end
    end
  end

  // Array is never reset directly; the clear sweep defines its contents
  always_ff @(posedge clk) begin
    if (!Rst) begin
      if (state == CLEAR) begin
        regdata[idx] <= (idx == SP_ADDR) ? SP_VAL : '0;
      end else begin
        if (a_acc) begin
          regdata[a_addr] <= a_data;
        end
        if (b_wr) begin
          regdata[b_addr] <= b_data;
        end
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rdport #(
      .XLEN(XLEN),
      .AW  (AW)
    ) u_rdport (
      .addr    (rd_addr[i]),
      .arr_data(regdata[rd_addr[i]]),
      .busy    (busy),
      .a_wen   (a_acc),
      .a_addr  (a_addr),
      .a_data  (a_data),
      .b_wen   (b_wr),
      .b_addr  (b_addr),
      .b_data  (b_data),
      .data    (rd_data[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a whole-register-file model checked every
// cycle, plus literal expectations for the clear, bypass and collision cases.
module tb_regfile_mp;

  logic             clk;
  logic             Rst;
  logic [2:0][4:0]  rd_addr;
  logic [2:0][31:0] rd_data;
  logic             a_we;
  logic [4:0]       a_addr;
  logic [31:0]      a_data;
  logic             b_valid;
  logic [4:0]       b_addr;
  logic [31:0]      b_data;
  logic             b_ready;
  logic             busy;

  int errors = 0;
  int checks = 0;

  regfile_mp dut (
    .clk    (clk),
    .Rst    (Rst),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .a_we   (a_we),
    .a_addr (a_addr),
    .a_data (a_data),
    .b_valid(b_valid),
    .b_addr (b_addr),
    .b_data (b_data),
    .b_ready(b_ready),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: busy_left counts clear cycles still owed; the clear lands atomically
  int          busy_left = -1;
  logic [31:0] mem [32];

  function automatic logic m_busy();
    return busy_left != 0;
  endfunction

  function automatic logic m_bready();
    if (m_busy()) return 1'b0;
    return !(a_we && a_addr != 0 && a_addr == b_addr);
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] addr);
    if (m_busy() || addr == 0) return 32'd0;
    if (a_we && a_addr == addr) return a_data;
    if (b_valid && m_bready() && b_addr == addr) return b_data;
    return mem[addr];
  endfunction

  always @(posedge clk) begin
    if (Rst) begin
      busy_left = 32;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) begin
        for (int r = 0; r < 32; r++) mem[r] = 32'd0;
        mem[2] = 32'd1020;
      end
    end else if (busy_left == 0) begin
      if (b_valid && m_bready() && b_addr != 0) mem[b_addr] = b_data;
      if (a_we && a_addr != 0) mem[a_addr] = a_data;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (busy_left >= 0) begin
      checkOutput("model busy", 32'(busy), 32'(m_busy()));
      checkOutput("model b_ready", 32'(b_ready), 32'(m_bready()));
      for (int p = 0; p < 3; p++) begin
        checkOutput($sformatf("model rd_data[%0d]", p), rd_data[p], m_read(rd_addr[p]));
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic awe, input logic [4:0] aa,
                               input logic [31:0] ad, input logic bv, input logic [4:0] ba,
                               input logic [31:0] bd, input logic [4:0] r0,
                               input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    Rst        = rst;
    a_we       = awe;
    a_addr     = aa;
    a_data     = ad;
    b_valid    = bv;
    b_addr     = ba;
    b_data     = bd;
    rd_addr[0] = r0;
    rd_addr[1] = r1;
    rd_addr[2] = r2;
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r0, r1, 5'd2);
  endtask

  task automatic countBusy(input string name);
    int cnt;
    cnt = 0;
    do begin
      idle(5'd2, 5'd5);
      if (busy) begin
        cnt++;
        checkOutput({name, " b_ready while busy"}, 32'(b_ready), 32'd0);
        checkOutput({name, " read while busy"}, rd_data[0], 32'd0);
      end
    end while (busy && cnt < 100);
    checkOutput({name, " busy cycles"}, cnt, 32'd32);
    checkOutput({name, " sp after clear"}, rd_data[0], 32'd1020);
  endtask

  initial begin
    Rst = 1'b1;
    a_we = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    rd_addr = '0;

    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd2, 5'd5, 5'd7);
    checkOutput("reset busy", 32'(busy), 32'd1);
    checkOutput("reset b_ready", 32'(b_ready), 32'd0);
    checkOutput("reset rd_data", rd_data[0] | rd_data[1] | rd_data[2], 32'd0);

    countBusy("clear");

    for (int i = 1; i < 32; i++) begin
      idle(5'(i), 5'd0);
      checkOutput($sformatf("cleared reg%0d", i), rd_data[0], (i == 2) ? 32'd1020 : 32'd0);
    end

    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd2);
    checkOutput("bypass same cycle", rd_data[0], 32'hDEADBEEF);
    idle(5'd5, 5'd0);
    checkOutput("bypass committed", rd_data[0], 32'hDEADBEEF);

    applyStimulus(1'b0, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 5'd7, 5'd0, 5'd2);
    checkOutput("collide b_ready", 32'(b_ready), 32'd0);
    checkOutput("collide port a wins", rd_data[0], 32'h11);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd0, 5'd2);
    checkOutput("collide retry b_ready", 32'(b_ready), 32'd1);
    checkOutput("collide retry bypass", rd_data[0], 32'h22);
    idle(5'd7, 5'd0);
    checkOutput("collide final reg7", rd_data[0], 32'h22);

    applyStimulus(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 5'd3, 5'd4, 5'd2);
    checkOutput("dual b_ready", 32'(b_ready), 32'd1);
    checkOutput("dual bypass a", rd_data[0], 32'hA);
    checkOutput("dual bypass b", rd_data[1], 32'hB);
    idle(5'd3, 5'd4);
    checkOutput("dual reg3", rd_data[0], 32'hA);
    checkOutput("dual reg4", rd_data[1], 32'hB);

    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd3, 5'd2);
    checkOutput("x0 b_ready", 32'(b_ready), 32'd1);
    checkOutput("x0 read", rd_data[0], 32'd0);
    idle(5'd0, 5'd3);
    checkOutput("x0 after", rd_data[0], 32'd0);
    checkOutput("x0 reg3 kept", rd_data[1], 32'hA);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd5, 5'd7);
    for (int i = 0; i < 10; i++) idle(5'd2, 5'd5);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd5, 5'd7);
    checkOutput("midclear busy", 32'(busy), 32'd1);
    countBusy("midclear");
    idle(5'd5, 5'd7);
    checkOutput("midclear reg5", rd_data[0], 32'd0);
    checkOutput("midclear reg7", rd_data[1], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count, power of two, at least 4; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 3: number of read ports.
REQ-004 SHALL have parameter SP_IDX, default 2: stack-pointer register index.
REQ-005 SHALL have parameter SP_INIT, default 1020: stack-pointer value loaded by the clear sequence.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-007 SHALL have port Rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port rd_addr, input, NRD x AW: read addresses.
REQ-009 SHALL have port rd_data, output, NRD x XLEN: read data.
REQ-010 SHALL have ports a_we (1), a_addr (AW) and a_data (XLEN), all inputs: pipeline writeback port; always accepted when not busy.
REQ-011 SHALL have ports b_valid (1), b_addr (AW) and b_data (XLEN) as inputs, and b_ready (1) as output: accelerator write port with a valid/ready handshake.
REQ-012 SHALL have port busy, output, 1 bit: clear sequence in progress.

Function
REQ-013 SHALL return 0 on rd_data[i] whenever rd_addr[i]==0; register 0 is never written.
REQ-014 SHALL be combinational on reads: rd_data reflects the current array contents in the same cycle.
REQ-015 SHALL bypass writes to reads: if a write to address X is accepted in cycle N, any read of X in cycle N returns the new data.
REQ-016 SHALL, when both ports write the same nonzero address in the same cycle, return port A's data on a bypassed read.
REQ-017 SHALL commit an accepted port-A write (a_we high, a_addr nonzero, not busy) at the next edge.
REQ-018 SHALL drive b_ready = !busy && !(a_we && a_addr==b_addr && a_addr!=0).
REQ-019 SHALL treat a port-B write as accepted only when b_valid && b_ready; it commits at the next edge, and data to address 0 is dropped but still handshaken.
REQ-020 SHALL allow writes to different addresses on both ports to commit in the same cycle.
REQ-021 SHALL hold b_ready low when port B's address collides with port A's write; port B must keep b_valid, b_addr and b_data stable until accepted.
REQ-022 SHALL implement a state machine with states IDLE and CLEAR plus an AW-bit clear index.
REQ-023 SHALL, in CLEAR, write each edge regdata[idx] <= (idx==SP_IDX ? SP_INIT : 0), then increment idx.
REQ-024 SHALL go CLEAR -> IDLE at the edge that writes idx==NREGS-1; idx wraps to 0.
REQ-025 SHALL hold busy=1 exactly while in CLEAR, which is NREGS cycles after Rst deasserts.
REQ-026 SHALL, while busy, ignore port-A writes, hold b_ready low and return 0 on all reads.
REQ-027 SHALL truncate SP_INIT to XLEN bits.

Reset
REQ-028 SHALL, on any edge with Rst high, force state=CLEAR and idx=0, and perform no array write.
REQ-029 SHALL restart the clear from idx 0 when Rst is asserted mid-clear.
REQ-030 SHALL have reset output values busy=1, b_ready=0 and rd_data=0.
REQ-031 SHALL not reset the array directly; contents are defined only after the clear completes.

Structure
REQ-032 SHALL place the state enum (IDLE, CLEAR) and the SP_IDX and SP_INIT defaults in shared package regfile_pkg.
REQ-033 SHALL implement the per-port read path (zero-check, bypass mux, busy gating) as sub-module regfile_rdport, instantiated NRD times.

Verification
REQ-034 SHALL cover reset clear: pulse Rst for 1 cycle -> busy high for 32 cycles, b_ready=0, reads return 0; afterwards reg2=1020 and regs 1..31 other than 2 read 0.
REQ-035 SHALL cover write bypass: a_we with a_addr=5 and a_data=0xDEADBEEF, with rd_addr[0]=5 in the same cycle -> rd_data[0]=0xDEADBEEF that cycle and thereafter.
REQ-036 SHALL cover a same-address collision: a_we with a_addr=7, a_data=0x11 and b_valid with b_addr=7, b_data=0x22 -> b_ready=0 and reg7=0x11; the next cycle b_ready=1 and reg7 becomes 0x22.
REQ-037 SHALL cover a dual write: port A writes 3 with 0xA and port B writes 4 with 0xB in the same cycle -> both commit and b_ready=1.
REQ-038 SHALL cover the x0 rule: a_we to address 0 with 0xFFFF and b_valid to address 0 -> reg0 reads 0 and port B is handshaken.
REQ-039 SHALL cover reset mid-clear: reassert Rst at clear cycle 10 -> busy stays high for a further 32 cycles after deassertion, and final reg2=1020.
